sequential_divider: RTL and testbench

Multi-cycle restoring (shift-subtract) integer divider. It is the inverse companion of the shift-and-add sequential multiplier and shares the same start/done handshake style. It produces one quotient bit per clock and trades latency for area. It sits in arithmetic datapaths beside the multiplier and is driven by a controlling FSM or CPU execute stage.

---
 rtl/sequential_divider.sv | 152 +++++++++++++++
 tb/tb_sequential_divider.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sequential_divider.sv
// Restoring shift-subtract divider, one quotient bit per clock.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands.
module sequential_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] d_r;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   t;
  logic             ge;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH-1:0] q_res;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic load;
  logic dz_load;
  logic fin;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic sq;
  logic sr;

  assign a_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign b_mag = divisor[WIDTH-1] ? -divisor : divisor;
  assign q_res = sq ? -q_nxt : q_nxt;
  assign r_res = sr ? -r_nxt : r_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq <= 1'b0;
      sr <= 1'b0;
    end else if (load) begin
      sq <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      sr <= dividend[WIDTH-1];
    end
  end
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign q_res = q_nxt;
  assign r_res = r_nxt;
`endif

  // R < D always holds, so T - D fits back into WIDTH bits
  assign t     = {r_r, q_r[WIDTH-1]};
  assign ge    = t >= {1'b0, d_r};
  assign r_nxt = ge ? WIDTH'(t - {1'b0, d_r})
                    : t[WIDTH-1:0];
  assign q_nxt = {q_r[WIDTH-2:0], ge};

  assign busy = (state == COMPUTE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    dz_load   = 1'b0;
    fin       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            dz_load   = 1'b1;
            state_nxt = DONE;
          end else begin
            load      = 1'b1;
            state_nxt = COMPUTE;
          end
        end
      end
      COMPUTE: begin
        if (cnt == LAST) begin
          fin       = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (!start) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= '0;
      r_r <= '0;
      d_r <= '0;
      cnt <= '0;
    end else if (load) begin
      q_r <= a_mag;
      r_r <= '0;
      d_r <= b_mag;
      cnt <= '0;
    end else if (state == COMPUTE) begin
      q_r <= q_nxt;
      r_r <= r_nxt;
      cnt <= cnt + CW'(1);
    end
  end

  // result registers only move on entry to DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (dz_load) begin
      quotient    <= '1;
      remainder   <= dividend;
      div_by_zero <= 1'b1;
    end else if (fin) begin
      quotient    <= q_res;
      remainder   <= r_res;
      div_by_zero <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sequential_divider.sv
// Randomized bench for sequential_divider against an arithmetic model.
// Honors SEQ_DIVIDER_SIGNED_EN for the signed build.
module tb_sequential_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sequential_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] f_q(input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    longint sa;
    longint sb;
    if (b == '0) return '1;
`ifdef SEQ_DIVIDER_SIGNED_EN
    sa = $signed(a);
    sb = $signed(b);
    return W'(sa / sb);
`else
    sa = longint'(a);
    sb = longint'(b);
    return W'(sa / sb);
`endif
  endfunction

  function automatic logic [W-1:0] f_r(input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    longint sa;
    longint sb;
    if (b == '0) return a;
`ifdef SEQ_DIVIDER_SIGNED_EN
    sa = $signed(a);
    sb = $signed(b);
    return W'(sa % sb);
`else
    sa = longint'(a);
    sb = longint'(b);
    return W'(sa % sb);
`endif
  endfunction

  // timeline model: 0 idle, 1 computing, 2 result presented
  int           m_phase;
  int           m_left;
  logic [W-1:0] m_q, m_r, p_q, p_r;
  logic         m_dz;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_left  <= 0;
      m_q     <= '0;
      m_r     <= '0;
      m_dz    <= 1'b0;
      p_q     <= '0;
      p_r     <= '0;
    end else begin
      case (m_phase)
        0: if (start) begin
          if (divisor == '0) begin
            m_phase <= 2;
            m_q     <= f_q(dividend, divisor);
            m_r     <= f_r(dividend, divisor);
            m_dz    <= 1'b1;
          end else begin
            m_phase <= 1;
            m_left  <= W;
            p_q     <= f_q(dividend, divisor);
            p_r     <= f_r(dividend, divisor);
          end
        end
        1: begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_phase <= 2;
            m_q     <= p_q;
            m_r     <= p_r;
            m_dz    <= 1'b0;
          end
        end
        2: if (!start) m_phase <= 0;
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", 64'(busy), 64'(m_phase == 1));
      chk("done", 64'(done), 64'(m_phase == 2));
      chk("quotient", 64'(quotient), 64'(m_q));
      chk("remainder", 64'(remainder), 64'(m_r));
      chk("div_by_zero", 64'(div_by_zero), 64'(m_dz));
    end
  end

  // hold = number of cycles start stays high (1 = single pulse)
  task automatic run(input logic [W-1:0] a,
                     input logic [W-1:0] b,
                     input int hold);
    int n;
    int lat;
    lat = (b == '0) ? 1 : W + 1;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    n        = 0;
    do begin
      @(negedge clk);
      n++;
      if (n >= hold) start = 1'b0;
      dividend = W'($urandom);
      divisor  = W'($urandom);
    end while (!done && n < 4 * W);
    chk("latency", 64'(n), 64'(lat));
    while (start) begin
      @(negedge clk);
      n++;
      if (n >= hold) start = 1'b0;
    end
  endtask

  task automatic expect_res(input string name,
                            input logic [W-1:0] q,
                            input logic [W-1:0] r,
                            input logic dz);
    chk({name, ".q"}, 64'(quotient), 64'(q));
    chk({name, ".r"}, 64'(remainder), 64'(r));
    chk({name, ".dz"}, 64'(div_by_zero), 64'(dz));
  endtask

  task automatic reset_midway;
    @(negedge clk);
    dividend = 8'd77;
    divisor  = 8'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_before_rst", 64'(busy), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("rst.q", 64'(quotient), 64'(0));
    chk("rst.r", 64'(remainder), 64'(0));
    chk("rst.dz", 64'(div_by_zero), 64'(0));
    chk("rst.busy", 64'(busy), 64'(0));
    chk("rst.done", 64'(done), 64'(0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    chk("init.q", 64'(quotient), 64'(0));
    chk("init.r", 64'(remainder), 64'(0));
    chk("init.dz", 64'(div_by_zero), 64'(0));
    chk("init.busy", 64'(busy), 64'(0));
    chk("init.done", 64'(done), 64'(0));
    rst = 1'b0;

    run(8'd100, 8'd7, 1);
    expect_res("100/7", 8'd14, 8'd2, 1'b0);
    run(8'd255, 8'd1, 1);
`ifdef SEQ_DIVIDER_SIGNED_EN
    expect_res("255/1", 8'hFF, 8'd0, 1'b0);
`else
    expect_res("255/1", 8'd255, 8'd0, 1'b0);
`endif
    run(8'd5, 8'd9, 1);
    expect_res("5/9", 8'd0, 8'd5, 1'b0);
    run(8'd42, 8'd0, 1);
    expect_res("42/0", 8'hFF, 8'd42, 1'b1);
    run(8'd42, 8'd6, 1);
    expect_res("42/6", 8'd7, 8'd0, 1'b0);
    run(8'd200, 8'd13, 20);
`ifdef SEQ_DIVIDER_SIGNED_EN
    expect_res("200/13", 8'hFC, 8'hFC, 1'b0);
`else
    expect_res("200/13", 8'd15, 8'd5, 1'b0);
`endif
    reset_midway();
    run(8'd77, 8'd3, 1);
    expect_res("77/3", 8'd25, 8'd2, 1'b0);

`ifdef SEQ_DIVIDER_SIGNED_EN
    run(8'h9C, 8'd7, 1);
    expect_res("-100/7", 8'hF2, 8'hFE, 1'b0);
    run(8'd100, 8'hF9, 1);
    expect_res("100/-7", 8'hF2, 8'h02, 1'b0);
    run(8'h80, 8'hFF, 1);
    expect_res("-128/-1", 8'h80, 8'h00, 1'b0);
    run(8'hFB, 8'd0, 1);
    expect_res("-5/0", 8'hFF, 8'hFB, 1'b1);
`endif

    repeat (60) begin
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      run(a, b, int'($urandom_range(1, 4)));
      expect_res("rand", f_q(a, b), f_r(a, b), b == '0);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
